conv3x3_tile_mac: RTL

Parametrised 3x3 convolution engine producing a 2x2 output tile per accepted 4x4 input window. It multiplies unsigned activations by signed weights and accumulates across any number of input-channel beats. On the last beat it applies ReLU, an arithmetic-shift requantisation, unsigned saturation and optional 2x2 max-pooling. It sits between the window-parsing/line-buffer stage and the output write-back, with valid/ready handshakes on both sides.

---
 rtl/conv3x3_tile_mac_pkg.sv | 34 +++
 rtl/conv3x3_dot.sv | 59 +++++
 rtl/conv3x3_tile_mac.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/conv3x3_tile_mac_pkg.sv
// Shared constants and width helpers for the 3x3 tile convolution engine.
package conv3x3_tile_mac_pkg;

    localparam int NLANES  = 4;   // 2x2 output tile
    localparam int NTAPS   = 9;   // 3x3 kernel
    localparam int WIN_DIM = 4;   // input window side
    localparam int KER_DIM = 3;   // kernel side
    localparam int OUT_DIM = 2;   // output tile side

    // Control fields travelling alongside a beat through the pipeline.
    typedef struct packed {
        logic       first;
        logic       last;
        logic [4:0] shift;
        logic       pool;
    } beatCtl_t;

    // Unsigned DW activation (zero-extended by one bit) times signed WW weight.
    function automatic int prodWidth(input int dw, input int ww);
        return dw + ww + 1;
    endfunction

    // Nine products need four extra bits of headroom.
    function automatic int sumWidth(input int dw, input int ww);
        return dw + ww + 5;
    endfunction

    // Window element feeding a given lane and kernel tap.
    function automatic int winIndex(input int lane, input int tap);
        return ((lane / OUT_DIM) + (tap / KER_DIM)) * WIN_DIM
             + (lane % OUT_DIM) + (tap % KER_DIM);
    endfunction

endpackage

// File: rtl/conv3x3_dot.sv
// One output lane: nine multipliers (S1 register) and an adder tree (S2 register).
module conv3x3_dot
    import conv3x3_tile_mac_pkg::*;
#(
    parameter int DW = 8,
    parameter int WW = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              en,
    input  logic [NTAPS*DW-1:0]               din,
    input  logic [NTAPS*WW-1:0]               wgt,
    output logic signed [sumWidth(DW,WW)-1:0] sum
);

    localparam int PW = prodWidth(DW, WW);
    localparam int SW = sumWidth(DW, WW);

    logic signed [PW-1:0] prodNext [NTAPS];
    logic signed [PW-1:0] prodQ    [NTAPS];
    logic signed [SW-1:0] treeSum;

    // Form the nine signed products of zero-extended activations and weights.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prodNext[k] = PW'($signed({1'b0, din[k*DW +: DW]})) * PW'($signed(wgt[k*WW +: WW]));
        end
    end

    // S1: register the products while the pipeline advances.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the product bank is plain flops, so it is reset like any other state; only true RAMs skip reset.
        if (!rstn) begin
            prodQ <= '{default: '0};
        end else if (en) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            prodQ <= prodNext;
        end
    end

    // Sum the registered products in full lane-sum precision.
    always_comb begin
        // NOTE: default assigned first so the combinational block can never infer a latch.
        treeSum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            treeSum = treeSum + SW'(prodQ[k]);
        end
    end

    // S2: register the lane sum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum <= '0;
        end else if (en) begin
            sum <= treeSum;
        end
    end

endmodule

// File: rtl/conv3x3_tile_mac.sv
// 3x3 convolution producing a 2x2 tile per 4x4 window, with channel accumulation,
// ReLU / shift / saturate requantisation and optional 2x2 max-pool.
module conv3x3_tile_mac
    import conv3x3_tile_mac_pkg::*;
#(
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int ACCW = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic                 i_first,
    input  logic                 i_last,
    input  logic [16*DW-1:0]     i_din,
    input  logic [9*WW-1:0]      i_wgt,
    input  logic [4:0]           i_shift,
    input  logic                 i_pool,
    output logic                 o_vld,
    input  logic                 o_rdy,
    output logic [4*DW-1:0]      o_data,
    output logic                 o_err
);

    localparam int SW = sumWidth(DW, WW);
    localparam logic [ACCW-1:0] QMAX = ACCW'((1 << DW) - 1);

    logic                   stall, adv, accept;
    beatCtl_t               inCtl, s1Ctl, s2Ctl;
    logic                   s1Vld, s2Vld;
    logic                   openQ;
    logic [NTAPS*DW-1:0]    laneWin  [NLANES];
    logic signed [SW-1:0]   laneSum  [NLANES];
    logic signed [ACCW-1:0] acc      [NLANES];
    logic signed [ACCW-1:0] accNext  [NLANES];
    logic signed [ACCW-1:0] shifted  [NLANES];
    logic [DW-1:0]          quant    [NLANES];
    logic [DW-1:0]          poolMax;
    logic [NLANES*DW-1:0]   tileNext;

    assign stall  = o_vld && !o_rdy;
    assign adv    = !stall;
    assign i_rdy  = adv;
    assign accept = i_vld && i_rdy;
    assign inCtl  = '{first: i_first, last: i_last, shift: i_shift, pool: i_pool};

    // Route each lane's 3x3 sub-window out of the 4x4 input window.
    always_comb begin
        for (int l = 0; l < NLANES; l++) begin
            for (int t = 0; t < NTAPS; t++) begin
                laneWin[l][t*DW +: DW] = i_din[winIndex(l, t)*DW +: DW];
            end
        end
    end

    for (genvar g = 0; g < NLANES; g++) begin : gLane
        conv3x3_dot #(.DW(DW), .WW(WW)) uDot (
            .clk  (clk),
            .rstn (rstn),
            .en   (adv),
            .din  (laneWin[g]),
            .wgt  (i_wgt),
            .sum  (laneSum[g])
        );
    end

    // Carry beat valid and control fields alongside the S1/S2 datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1Vld <= 1'b0;
            s2Vld <= 1'b0;
            s1Ctl <= '0;
            s2Ctl <= '0;
        end else if (adv) begin
            s1Vld <= i_vld;
            s1Ctl <= inCtl;
            s2Vld <= s1Vld;
            s2Ctl <= s1Ctl;
        end
    end

    // Accumulate, then requantise and optionally pool the updated accumulators.
    always_comb begin
        tileNext = '0;
        poolMax  = '0;
        for (int l = 0; l < NLANES; l++) begin
            accNext[l] = (s2Ctl.first ? ACCW'(0) : acc[l]) + ACCW'(laneSum[l]);
            shifted[l] = accNext[l] >>> s2Ctl.shift;
            if (accNext[l][ACCW-1]) begin
                quant[l] = '0;
            end else if ($unsigned(shifted[l]) > QMAX) begin
                quant[l] = '1;
            end else begin
                quant[l] = shifted[l][DW-1:0];
            end
            if (quant[l] > poolMax) begin
                poolMax = quant[l];
            end
            tileNext[l*DW +: DW] = quant[l];
        end
        if (s2Ctl.pool) begin
            tileNext           = '0;
            tileNext[DW-1:0]   = poolMax;
        end
    end

    // S3: update the accumulators; they return to zero after each last beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '{default: '0};
        end else if (adv && s2Vld) begin
            for (int l = 0; l < NLANES; l++) begin
                acc[l] <= s2Ctl.last ? '0 : accNext[l];
            end
        end
    end

    // S3: output register; a new tile may replace one being consumed this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vld  <= 1'b0;
            o_data <= '0;
        end else if (adv) begin
            if (s2Vld && s2Ctl.last) begin
                o_vld  <= 1'b1;
                o_data <= tileNext;
            end else begin
                o_vld  <= 1'b0;
            end
        end
    end

    // Flag a first beat arriving while a reduction is still open; sticky until reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            openQ <= 1'b0;
            o_err <= 1'b0;
        end else if (accept) begin
            if (i_first && openQ) begin
                o_err <= 1'b1;
            end
            if (i_last) begin
                openQ <= 1'b0;
            end else if (i_first) begin
                openQ <= 1'b1;
            end
        end
    end

endmodule
